// File: rtl/req_rr_arbiter_8.sv
// req_rr_arbiter_8
//   Upstream request stage for an 8:3 encoder. Request events on 8 lines are
//   captured into pending bits. One enabled pending bit is chosen round-robin
//   and presented as a registered one-hot grant plus enable. The grant is held
//   until the consumer acknowledges it, and the acknowledged request is then retired.
//
//   Ports:
//     clk          - clock, all logic on posedge
//     rst          - synchronous active-high reset
//     req_in       - request lines (synchronous to clk)
//     req_enable   - per-line capture/grant enable
//     grant_onehot - registered one-hot grant (encoder data input)
//     grant_en     - grant valid (encoder enable)
//     grant_ack    - consumer accepts current grant (ignored while grant_en=0)
//     pending      - current pending bits
//     dropped      - sticky flag: edge event lost on an already-pending line
//     clr_dropped  - clears dropped (a simultaneous set wins)
module req_rr_arbiter_8 #(
  parameter int unsigned EDGE_MODE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req_in,
  input  logic [7:0] req_enable,
  output logic [7:0] grant_onehot,
  output logic       grant_en,
  input  logic       grant_ack,
  output logic [7:0] pending,
  output logic       dropped,
  input  logic       clr_dropped
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [7:0] req_q, req_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] grant_onehot_q, grant_onehot_d;
  logic       grant_en_q, grant_en_d;
  logic [2:0] rr_ptr_q, rr_ptr_d;
  logic       dropped_q, dropped_d;

  logic [7:0] ev;
  logic [7:0] retire;
  logic [7:0] eligible;
  logic       drop_set;
  logic [2:0] sel_idx;
  logic       sel_found;
  logic [2:0] cand;
  logic [2:0] gnt_idx;

  // Event capture and pending/dropped bookkeeping
  always_comb begin
    req_d     = req_in;
    ev        = (EDGE_MODE != 0) ? (req_in & ~req_q & req_enable)
                                 : (req_in & req_enable);
    retire    = (state_q == GRANT && grant_ack) ? grant_onehot_q : '0;
    // Set wins over retire so an event on the granted line in its ack cycle survives
    pending_d = ev | (pending_q & ~retire);
    drop_set  = (EDGE_MODE != 0) && (|(ev & pending_q & ~retire));
    dropped_d = drop_set | (dropped_q & ~clr_dropped);
  end

  // Round-robin search: first eligible bit at or after rr_ptr, wrapping 7->0.
  // The 3-bit addition wraps naturally.
  always_comb begin
    eligible  = pending_q & req_enable;
    sel_idx   = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      cand = rr_ptr_q + i[2:0];
      if (!sel_found && eligible[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Index of the current grant, used to advance the pointer on ack
  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (grant_onehot_q[i]) gnt_idx = i[2:0];
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_onehot_d = grant_onehot_q;
    grant_en_d     = grant_en_q;
    rr_ptr_d       = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant_onehot_d = 8'b1 << sel_idx;
          grant_en_d     = 1'b1;
          state_d        = GRANT;
        end
      end
      GRANT: begin
        if (grant_ack) begin
          rr_ptr_d       = gnt_idx + 3'd1;
          grant_onehot_d = '0;
          grant_en_d     = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      req_q          <= '0;
      pending_q      <= '0;
      grant_onehot_q <= '0;
      grant_en_q     <= 1'b0;
      rr_ptr_q       <= '0;
      dropped_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_q          <= req_d;
      pending_q      <= pending_d;
      grant_onehot_q <= grant_onehot_d;
      grant_en_q     <= grant_en_d;
      rr_ptr_q       <= rr_ptr_d;
      dropped_q      <= dropped_d;
    end
  end

  assign grant_onehot = grant_onehot_q;
  assign grant_en     = grant_en_q;
  assign pending      = pending_q;
  assign dropped      = dropped_q;

endmodule

// File: tb/tb_req_rr_arbiter_8.sv
module tb_req_rr_arbiter_8;

  typedef struct packed {
    bit [7:0] pend;
    bit [7:0] prev;
    bit       busy;
    bit       drop;
    int       ptr;
    int       gidx;
  } mstate_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_in, req_enable;
  logic       grant_ack, clr_dropped;

  logic [7:0] g_e, p_e, g_l, p_l;
  logic       en_e, d_e, en_l, d_l;

  int errors = 0;
  int checks = 0;
  bit armed = 1'b0;

  mstate_t me, ml;
  bit [7:0] qe[$];
  bit [7:0] ql[$];
  bit prev_en_e = 1'b0;
  bit prev_en_l = 1'b0;

  always #5 clk = ~clk;

  req_rr_arbiter_8 #(.EDGE_MODE(1)) dut_e (
    .clk(clk), .rst(rst), .req_in(req_in), .req_enable(req_enable),
    .grant_onehot(g_e), .grant_en(en_e), .grant_ack(grant_ack),
    .pending(p_e), .dropped(d_e), .clr_dropped(clr_dropped)
  );

  req_rr_arbiter_8 #(.EDGE_MODE(0)) dut_l (
    .clk(clk), .rst(rst), .req_in(req_in), .req_enable(req_enable),
    .grant_onehot(g_l), .grant_en(en_l), .grant_ack(grant_ack),
    .pending(p_l), .dropped(d_l), .clr_dropped(clr_dropped)
  );

  // Reference model: one clock step of the arbiter's documented rules
  function automatic mstate_t step(mstate_t s, bit em, bit r, bit [7:0] rin,
                                   bit [7:0] en, bit ack, bit clr);
    mstate_t n;
    bit [7:0] retire;
    bit ev, set_drop, found;
    int j;
    n = s;
    retire = '0;
    set_drop = 1'b0;
    found = 1'b0;
    if (r) begin
      n = '0;
      return n;
    end
    if (s.busy && ack) retire[s.gidx] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ev = en[i] && rin[i] && (!em || !s.prev[i]);
      if (ev) begin
        if (em && s.pend[i] && !retire[i]) set_drop = 1'b1;
        n.pend[i] = 1'b1;
      end else if (retire[i]) begin
        n.pend[i] = 1'b0;
      end
    end
    n.drop = set_drop ? 1'b1 : (clr ? 1'b0 : s.drop);
    n.prev = rin;
    if (s.busy) begin
      if (ack) begin
        n.busy = 1'b0;
        n.ptr  = (s.gidx + 1) % 8;
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        j = (s.ptr + k) % 8;
        if (!found && s.pend[j] && en[j]) begin
          found  = 1'b1;
          n.busy = 1'b1;
          n.gidx = j;
        end
      end
    end
    return n;
  endfunction

  function automatic bit [7:0] oh(mstate_t s);
    bit [7:0] v;
    v = '0;
    if (s.busy) v[s.gidx] = 1'b1;
    return v;
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model advance; new grants go into the scoreboard queues
  always @(posedge clk) begin
    mstate_t ne, nl;
    ne = step(me, 1'b1, rst, req_in, req_enable, grant_ack, clr_dropped);
    nl = step(ml, 1'b0, rst, req_in, req_enable, grant_ack, clr_dropped);
    if (!me.busy && ne.busy) qe.push_back(oh(ne));
    if (!ml.busy && nl.busy) ql.push_back(oh(nl));
    me = ne;
    ml = nl;
  end

  // Monitor: per-cycle state compare plus scoreboard pop on each new grant
  always @(negedge clk) begin
    if (armed) begin
      chk("e.pending", p_e, me.pend);
      chk("e.grant_en", {7'b0, en_e}, {7'b0, me.busy});
      chk("e.grant_onehot", g_e, oh(me));
      chk("e.dropped", {7'b0, d_e}, {7'b0, me.drop});
      chk("l.pending", p_l, ml.pend);
      chk("l.grant_en", {7'b0, en_l}, {7'b0, ml.busy});
      chk("l.grant_onehot", g_l, oh(ml));
      chk("l.dropped", {7'b0, d_l}, {7'b0, ml.drop});
      if (en_e && !prev_en_e) begin
        if (qe.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL e.sb_grant: got %h expected none queued", g_e);
        end else chk("e.sb_grant", g_e, qe.pop_front());
      end
      if (en_l && !prev_en_l) begin
        if (ql.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL l.sb_grant: got %h expected none queued", g_l);
        end else chk("l.sb_grant", g_l, ql.pop_front());
      end
      prev_en_e = en_e;
      prev_en_l = en_l;
    end
  end

  task automatic cyc(bit r, bit [7:0] rin, bit [7:0] en, bit ack, bit clr);
    @(posedge clk);
    #1;
    rst         = r;
    req_in      = rin;
    req_enable  = en;
    grant_ack   = ack;
    clr_dropped = clr;
  endtask

  initial begin
    bit [7:0] rin, en, flip;
    rst = 1'b1; req_in = 8'hFF; req_enable = 8'hFF; grant_ack = 1'b0; clr_dropped = 1'b0;
    me = '0; ml = '0;
    cyc(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0);
    armed = 1'b1;
    cyc(1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0);
    // Line held high through reset is seen as an edge right after release
    cyc(1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1.pending_ff", p_e, 8'hFF);
    chk("t1.no_grant_yet", {7'b0, en_e}, 8'h00);
    cyc(1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1.first_grant", g_e, 8'h01);

    rin = 8'h00;
    en  = 8'hFF;
    for (int c = 0; c < 3000; c++) begin
      flip = '0;
      for (int b = 0; b < 8; b++) flip[b] = ($urandom_range(0, 7) == 0);
      rin = rin ^ flip;
      if ($urandom_range(0, 19) == 0) en = 8'($urandom);
      if ($urandom_range(0, 29) == 0) en = 8'hFF;
      cyc($urandom_range(0, 199) == 0, rin, en,
          $urandom_range(0, 99) < 40, $urandom_range(0, 19) == 0);
    end

    // Level mode: line 0 held high with constant ack gives grant/bubble repeats
    cyc(1'b1, 8'h00, 8'hFF, 1'b0, 1'b0);
    for (int c = 0; c < 30; c++) cyc(1'b0, 8'h01, 8'hFF, 1'b1, 1'b0);
    for (int c = 0; c < 10; c++) cyc(1'b0, 8'h00, 8'hFF, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("e.queue_drained", 8'(qe.size()), 8'h00);
    chk("l.queue_drained", 8'(ql.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
